ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_W, default 32, operand width; SHALL be even and >= 8.
REQ-002 Parameter ITER_BITS, default $clog2(DATA_W)+1, iteration counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  request a new operation; sampled only in IDLE.
REQ-006 op_i  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 opdata1_i  in  DATA_W  multiplicand / dividend.
REQ-008 opdata2_i  in  DATA_W  multiplier / divisor.
REQ-009 annul_i  in  1  pipeline flush; abort any operation in progress.
REQ-010 busy_o  out  1  stall request; high whenever state != IDLE.
REQ-011 ready_o  out  1  one-cycle pulse, result valid on hi_o/lo_o.
REQ-012 dz_o  out  1  divide-by-zero flag, valid with ready_o.
REQ-013 hi_o  out  DATA_W  product high half / remainder.
REQ-014 lo_o  out  DATA_W  product low half / quotient.

Function
REQ-015 FSM states IDLE, RUN, DZERO, DONE; busy_o SHALL be combinational from state.
REQ-016 IDLE: start_i=1 and annul_i=0 -> latch op and operand magnitudes; divisor 0 with DIV/DIVU -> DZERO, else RUN with counter=0.
REQ-017 Signed ops: operands converted to magnitude on entry; -2^(DATA_W-1) -> magnitude 2^(DATA_W-1), unsigned, no overflow.
REQ-018 RUN: one radix-2 step per cycle (shift-add multiply / restoring divide); exactly DATA_W cycles, then DONE.
REQ-019 DONE: ready_o=1 for one cycle, hi_o/lo_o updated on the edge entering DONE; next state IDLE.
REQ-020 Latency: start accepted at edge 0 -> ready_o high in cycle DATA_W+1 (33 at DATA_W=32); divide-by-zero -> ready_o in cycle 2.
REQ-021 MULT/MULTU: {hi_o,lo_o} = full 2*DATA_W product; signed product negated when operand signs differ.
REQ-022 DIV/DIVU: lo_o=quotient, hi_o=remainder; signed quotient sign = s1^s2, remainder sign = dividend sign; truncation toward zero.
REQ-023 DIV -2^(DATA_W-1) / -1 -> quotient wraps to -2^(DATA_W-1), remainder 0, dz_o=0.
REQ-024 Divide by zero: hi_o=lo_o=0, dz_o=1 for the ready cycle; dz_o=0 on all other completions.
REQ-025 annul_i=1 in any state -> IDLE on next edge, no ready_o, hi_o/lo_o unchanged; annul wins over simultaneous start_i.
REQ-026 start_i outside IDLE (including DONE cycle) SHALL be ignored; operands need only be valid in the start cycle.
REQ-027 hi_o/lo_o SHALL hold last completed result between operations.

Reset
REQ-028 rst asserted -> state IDLE, counter 0, hi_o=lo_o=0, ready_o=0, dz_o=0, busy_o=0, immediately and regardless of clk.
REQ-029 rst mid-operation SHALL abort without ready_o; first start after deassertion behaves as from power-up.

Structure
REQ-030 Op encodings, FSM state encodings and result-select constants SHALL live in the shared defines package, alongside existing ALU op codes.
REQ-031 One sub-module, muldiv_step: combinational single iteration (partial-product add or trial subtract) instantiated once in ex_muldiv.
REQ-032 Sign conditioning and final negation SHALL stay in ex_muldiv; no other sub-modules.

Verification (DATA_W=32)
REQ-033 MULT -3 x 5 -> ready_o cycle 33, hi_o=FFFFFFFF, lo_o=FFFFFFF1, busy_o high cycles 1-33.
REQ-034 MULTU FFFFFFFF x FFFFFFFF -> hi_o=FFFFFFFE, lo_o=00000001.
REQ-035 DIV -7 / 2 -> lo_o=FFFFFFFD, hi_o=FFFFFFFF; DIV 80000000 / FFFFFFFF -> lo_o=80000000, hi_o=0.
REQ-036 DIVU 1234 / 0 -> ready_o cycle 2, dz_o=1, hi_o=lo_o=0.
REQ-037 DIVU 100/7 with annul_i at cycle 10 -> no ready_o, busy_o low cycle 11; new MULTU 6x7 started cycle 11 -> lo_o=2A, hi_o=0.
REQ-038 rst pulsed mid-RUN (cycle 5, unclocked) -> outputs zero at once, no ready_o afterwards.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared execute-stage definitions: ALU op codes plus the multiply/divide
// unit's op encodings, FSM state encodings and result-select constants.
// Helper functions classify a multiply/divide op.
package ex_muldiv_pkg;

    // ALU op codes used by the rest of the execute stage.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9
    } alu_op_e;

    // Multiply/divide op codes, matching the op_i port encoding.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_RUN   = 2'b01,
        MD_DZERO = 2'b10,
        MD_DONE  = 2'b11
    } md_state_e;

    // Selects how the final hi/lo result is formed from the iteration state.
    typedef enum logic [1:0] {
        MD_RES_PROD = 2'b00,
        MD_RES_DIV  = 2'b01,
        MD_RES_ZERO = 2'b10
    } md_res_sel_e;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide unit, purely combinational.
//   op      : selects shift-add multiply or restoring divide
//   acc_hi  : partial product high half / partial remainder
//   acc_lo  : multiplier being shifted out / dividend shifting into quotient
//   operand : multiplicand magnitude / divisor magnitude
//   next_hi, next_lo : accumulator after this iteration
module muldiv_step
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  md_op_e            op,
    input  logic [DATA_W-1:0] acc_hi,
    input  logic [DATA_W-1:0] acc_lo,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] next_hi,
    output logic [DATA_W-1:0] next_lo
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              ge;

    always_comb begin
        // Multiply: conditionally add, then shift the carry into the top.
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // Divide: shift the next dividend bit into the remainder, trial subtract.
        // When the trial succeeds the difference is below the divisor, so the
        // low DATA_W bits of the subtraction are exact.
        shifted = {acc_hi, acc_lo[DATA_W-1]};
        ge      = shifted >= {1'b0, operand};
        diff    = shifted[DATA_W-1:0] - operand;
        if (md_is_div(op)) begin
            next_hi = ge ? diff : shifted[DATA_W-1:0];
            next_lo = {acc_lo[DATA_W-2:0], ge};
        end else begin
            next_hi = sum[DATA_W:1];
            next_lo = {sum[0], acc_lo[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the execute stage.
// Signed operands are reduced to magnitudes on entry, one radix-2 step runs
// per cycle for DATA_W cycles, and the sign is restored on the final edge.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start_i, op_i         : start request (taken in IDLE only) and op select
//   opdata1_i, opdata2_i  : multiplicand/dividend, multiplier/divisor
//   annul_i               : flush, aborts any operation without a result
//   busy_o                : stall request, high whenever not IDLE
//   ready_o, dz_o         : one-cycle completion pulse, divide-by-zero flag
//   hi_o, lo_o            : product high/low or remainder/quotient
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ITER_BITS = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              annul_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic              dz_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    md_state_e          state_q, state_d;
    logic [ITER_BITS-1:0] count_q;
    md_op_e             op_q;
    logic               neg_res_q, neg_rem_q;
    logic [DATA_W-1:0]  acc_hi_q, acc_lo_q, operand_q;
    logic [DATA_W-1:0]  step_hi, step_lo;
    logic [DATA_W-1:0]  hi_q, lo_q;
    logic               dz_q;

    md_op_e             op_in;
    logic               accept, last_iter;
    logic               s1, s2;
    logic [DATA_W-1:0]  mag1, mag2;
    md_res_sel_e        res_sel;
    logic [DATA_W-1:0]  res_hi, res_lo;

    // Two's-complement negate when requested; -2^(DATA_W-1) maps to its own
    // bit pattern, which read unsigned is the correct magnitude.
    function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                      input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] cond_negate_wide(input logic [2*DATA_W-1:0] v,
                                                             input logic neg);
        return neg ? -v : v;
    endfunction

    // Entry: sign conditioning of the incoming operands
    assign op_in     = md_op_e'(op_i);
    assign s1        = md_is_signed(op_in) & opdata1_i[DATA_W-1];
    assign s2        = md_is_signed(op_in) & opdata2_i[DATA_W-1];
    assign mag1      = cond_negate(opdata1_i, s1);
    assign mag2      = cond_negate(opdata2_i, s2);
    assign accept    = (state_q == MD_IDLE) && start_i && !annul_i;
    assign last_iter = (count_q == ITER_BITS'(DATA_W - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    state_d = (md_is_div(op_in) && (opdata2_i == '0)) ? MD_DZERO : MD_RUN;
                end
            end
            MD_RUN:   if (last_iter) state_d = MD_DONE;
            MD_DZERO: state_d = MD_DONE;
            MD_DONE:  state_d = MD_IDLE;
            default:  state_d = MD_IDLE;
        endcase
        // A flush takes priority over everything, including a fresh start.
        if (annul_i) state_d = MD_IDLE;
    end

    // Iteration: one radix-2 step per RUN cycle
    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .op      (op_q),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (operand_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= op_in;
            neg_res_q <= s1 ^ s2;
            neg_rem_q <= s1;
            acc_hi_q  <= '0;
            if (md_is_div(op_in)) begin
                acc_lo_q  <= mag1;
                operand_q <= mag2;
            end else begin
                acc_lo_q  <= mag2;
                operand_q <= mag1;
            end
        end else if (state_q == MD_RUN) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
        end
    end

    // Completion: restore signs from the final step's output
    always_comb begin
        res_sel = MD_RES_PROD;
        if (state_q == MD_DZERO) res_sel = MD_RES_ZERO;
        else if (md_is_div(op_q)) res_sel = MD_RES_DIV;
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        unique case (res_sel)
            MD_RES_PROD: {res_hi, res_lo} = cond_negate_wide({step_hi, step_lo}, neg_res_q);
            MD_RES_DIV: begin
                res_lo = cond_negate(step_lo, neg_res_q);
                res_hi = cond_negate(step_hi, neg_rem_q);
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                count_q <= '0;
            end else if (state_q == MD_RUN) begin
                count_q <= count_q + 1'b1;
            end
            // Results only change on the edge entering DONE; a flush on that
            // same edge leaves the previous result in place.
            if (!annul_i) begin
                if ((state_q == MD_RUN) && last_iter) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                    dz_q <= 1'b0;
                end else if (state_q == MD_DZERO) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                    dz_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o  = (state_q != MD_IDLE);
    assign ready_o = (state_q == MD_DONE);
    assign dz_o    = (state_q == MD_DONE) && dz_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        busy_o, ready_o, dz_o;
    logic [31:0] hi_o, lo_o;

    ex_muldiv #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .busy_o    (busy_o),
        .ready_o   (ready_o),
        .dz_o      (dz_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Behavioural model: expected busy window, completion cycle and results.
    int          busy_lo = 1, busy_hi = 0, ready_at = -1;
    logic [31:0] pend_hi = '0, pend_lo = '0, held_hi = '0, held_lo = '0;
    logic        pend_dz = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns {dz, hi, lo} from plain arithmetic on the operands.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: begin p = sa * sb; return {1'b0, p}; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
            2'b10: begin
                if (b == 0) return {1'b1, 64'd0};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, 64'd0};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc == ready_at) begin
                held_hi = pend_hi;
                held_lo = pend_lo;
            end
            check("busy",  64'(busy_o),  64'((cyc >= busy_lo) && (cyc <= busy_hi)));
            check("ready", 64'(ready_o), 64'(cyc == ready_at));
            check("dz",    64'(dz_o),    64'((cyc == ready_at) && pend_dz));
            check("hi",    64'(hi_o),    64'(held_hi));
            check("lo",    64'(lo_o),    64'(held_lo));
        end
    end

    task automatic step_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int acc_edge);
        logic [64:0] m;
        int lat;
        m   = model(op, a, b);
        lat = (op[1] && (b == 0)) ? 1 : DATA_W;
        start_i   = 1'b1;
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        acc_edge  = cyc + 1;
        busy_lo   = acc_edge;
        busy_hi   = acc_edge + lat;
        ready_at  = acc_edge + lat;
        pend_dz   = m[64];
        pend_hi   = m[63:32];
        pend_lo   = m[31:0];
        step_cycle();
        // Operands only need to be valid in the start cycle.
        start_i   = 1'b0;
        op_i      = 2'($urandom_range(3));
        opdata1_i = $urandom;
        opdata2_i = $urandom;
    endtask

    task automatic wait_done();
        while (cyc <= ready_at) step_cycle();
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit_hi,
                          input logic [31:0] lit_lo);
        int a_e;
        drive_start(op, a, b, a_e);
        wait_done();
        check({name, "_hi"}, 64'(hi_o), 64'(lit_hi));
        check({name, "_lo"}, 64'(lo_o), 64'(lit_lo));
    endtask

    task automatic clear_model();
        busy_lo  = 1;
        busy_hi  = 0;
        ready_at = -1;
        held_hi  = '0;
        held_lo  = '0;
        pend_dz  = 1'b0;
    endtask

    initial begin
        int a_e;
        repeat (2) step_cycle();
        check("rst_busy",  64'(busy_o),  64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_dz",    64'(dz_o),    64'd0);
        check("rst_hi",    64'(hi_o),    64'd0);
        check("rst_lo",    64'(lo_o),    64'd0);
        rst = 1'b0;
        step_cycle();

        // MULT -3 x 5 with starts issued mid-run and in the DONE cycle.
        drive_start(2'b00, 32'hFFFF_FFFD, 32'd5, a_e);
        check("mult_busy_c1", 64'(busy_o), 64'd1);
        repeat (3) step_cycle();
        start_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd9; opdata2_i = 32'd0;
        step_cycle();
        start_i = 1'b0;
        while (cyc < a_e + 32) step_cycle();
        check("mult_ready_c33", 64'(ready_o), 64'd1);
        check("mult_busy_c33",  64'(busy_o),  64'd1);
        start_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd5; opdata2_i = 32'd0;
        step_cycle();
        start_i = 1'b0;
        check("mult_busy_c34", 64'(busy_o), 64'd0);
        check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo_o), 64'hFFFF_FFF1);
        step_cycle();

        run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_7_m2",   2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("mult_7_m1",  2'b00, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run_op("divu_max_1", 2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF);

        // DIVU 1234 / 0: ready in cycle 2 with dz set.
        drive_start(2'b11, 32'd1234, 32'd0, a_e);
        step_cycle();
        check("dz_ready_c2", 64'(ready_o), 64'd1);
        check("dz_flag_c2",  64'(dz_o),    64'd1);
        wait_done();
        check("dz_hi", 64'(hi_o), 64'd0);
        check("dz_lo", 64'(lo_o), 64'd0);
        run_op("div_m8_0",   2'b10, 32'hFFFF_FFF8, 32'd0,         32'h0000_0000, 32'h0000_0000);
        run_op("divu_100_7", 2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);

        // Flush together with start in IDLE: nothing starts.
        start_i = 1'b1; annul_i = 1'b1; op_i = 2'b00; opdata1_i = 32'd3; opdata2_i = 32'd3;
        step_cycle();
        start_i = 1'b0; annul_i = 1'b0;
        check("annul_start_idle", 64'(busy_o), 64'd0);
        step_cycle();

        // DIVU 100/7 flushed in cycle 10, MULTU 6x7 started in cycle 11.
        drive_start(2'b11, 32'd100, 32'd7, a_e);
        repeat (9) step_cycle();
        annul_i  = 1'b1;
        busy_hi  = cyc;
        ready_at = -1;
        check("annul_busy_c10", 64'(busy_o), 64'd1);
        step_cycle();
        annul_i = 1'b0;
        check("annul_busy_c11", 64'(busy_o), 64'd0);
        drive_start(2'b01, 32'd6, 32'd7, a_e);
        wait_done();
        check("multu_6x7_hi", 64'(hi_o), 64'd0);
        check("multu_6x7_lo", 64'(lo_o), 64'h2A);

        // Reset asserted between clock edges in cycle 5 of a divide.
        drive_start(2'b10, 32'hFFFF_FFF9, 32'd2, a_e);
        repeat (4) step_cycle();
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        check("rstmid_busy",  64'(busy_o),  64'd0);
        check("rstmid_ready", 64'(ready_o), 64'd0);
        check("rstmid_dz",    64'(dz_o),    64'd0);
        check("rstmid_hi",    64'(hi_o),    64'd0);
        check("rstmid_lo",    64'(lo_o),    64'd0);
        step_cycle();
        rst = 1'b0;
        repeat (DATA_W + 3) step_cycle();
        run_op("post_rst_div", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        repeat (2) step_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
